// File: rtl/piso_bit_serializer_if.sv
// Parallel-word handshake feeding the serializer: upstream (master) offers din/din_valid,
// the serializer (slave) answers with a combinational din_ready.
interface piso_bit_serializer_if #(
  parameter int DW = 8
);
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: takes DW-bit words over valid/ready and emits one bit per
// clock with no gap between back-to-back words; idle fill is IDLE_BIT.
module piso_bit_serializer #(
  parameter int DW        = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  piso_bit_serializer_if.slave    in_if,
  output logic                    sout_o,
  output logic                    sout_valid_o,
  output logic                    sout_last_o
);

  localparam int              CW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(DW - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic            sout_q, sout_d;
  logic            sout_valid_q, sout_valid_d;
  logic            sout_last_q, sout_last_d;

  logic            din_ready;
  logic            accept;
  logic            first_bit;
  logic            next_bit;
  logic [DW-1:0]   shreg_adv;
  logic [CW-1:0]   cnt_inc;

  // Ready is a function of state only, so upstream may use it to decide din_valid.
  assign din_ready       = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && (cnt_q == LAST_IDX));
  assign in_if.din_ready = din_ready;
  assign accept          = in_if.din_valid && din_ready;
  assign cnt_inc         = cnt_q + 1'b1;

  // The bit leaving next always sits one position behind the one currently on the line.
  generate
    if (MSB_FIRST) begin : g_msb
      assign first_bit = in_if.din[DW-1];
      assign next_bit  = shreg_q[DW-2];
      assign shreg_adv = shreg_q << 1;
    end else begin : g_lsb
      assign first_bit = in_if.din[0];
      assign next_bit  = shreg_q[1];
      assign shreg_adv = shreg_q >> 1;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    sout_last_d  = sout_last_q;

    if (accept) begin
      state_d      = ST_SHIFT;
      cnt_d        = '0;
      shreg_d      = in_if.din;
      sout_d       = first_bit;
      sout_valid_d = 1'b1;
      sout_last_d  = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      if (cnt_q != LAST_IDX) begin
        cnt_d       = cnt_inc;
        shreg_d     = shreg_adv;
        sout_d      = next_bit;
        sout_last_d = (cnt_inc == LAST_IDX);
      end else begin
        state_d      = ST_IDLE;
        cnt_d        = '0;
        sout_d       = IDLE_BIT;
        sout_valid_d = 1'b0;
        sout_last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_last_q  <= sout_last_d;
    end
  end

  assign sout_o       = sout_q;
  assign sout_valid_o = sout_valid_q;
  assign sout_last_o  = sout_last_q;

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the serial sequence detector.
- Accepts DW-bit words over a valid/ready handshake and drives them one bit per clock onto a serial line that the detector samples every cycle.
- Back-to-back words are emitted with no gap, so bit patterns can straddle word boundaries.
- The line is held at IDLE_BIT when no word is being shifted.

Parameters:
DW, 8, word width in bits; legal range DW >= 2.
MSB_FIRST, 1, 1 = bit DW-1 is sent first; 0 = bit 0 is sent first.
IDLE_BIT, 1'b0, level driven on sout while no word is active.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
din  input  DW  parallel word.
din_valid  input  1  din is valid this cycle.
din_ready  output  1  combinational; block accepts din at this edge.
sout  output  1  registered serial bit; connects to the detector's sin.
sout_valid  output  1  registered; sout carries a data bit, not idle fill.
sout_last  output  1  registered; sout carries the final bit of the current word.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, sout=IDLE_BIT, sout_valid=0, sout_last=0, bit counter cnt=0, shift register=0.
- States:
  - IDLE: no word active.
  - SHIFT: a word is on the line; cnt = index (0..DW-1) of the bit currently on sout.
- din_ready = (state==IDLE) || (state==SHIFT && cnt==DW-1). It depends only on state and cnt, never on din_valid.
- Accept = din_valid && din_ready at a rising edge. On accept:
  - sout <= first bit of din, selected by MSB_FIRST.
  - Shift register <= din.
  - cnt <= 0, sout_valid <= 1, state <= SHIFT.
  - sout_last <= 0.
- Latency: word accepted at edge k; its first bit is on sout from edge k to edge k+1. Its last bit is on sout from edge k+DW-1 to edge k+DW.
- SHIFT with cnt<DW-1: sout <= next bit in order, cnt <= cnt+1. sout_last <= 1 when the new cnt is DW-1.
- SHIFT with cnt==DW-1 (last bit on line):
  - If accept: reload as above, with no idle cycle between words.
  - Otherwise: state <= IDLE, sout <= IDLE_BIT, sout_valid <= 0, sout_last <= 0, cnt <= 0.
- din_valid while din_ready=0: no effect. Upstream must hold din_valid/din; din changes while not ready are ignored.
- din is sampled only at the accept edge; later din changes do not affect the word in flight.
- cnt is wide enough to hold DW-1 ($clog2(DW) bits) and never exceeds DW-1.
- Reset asserted mid-word: word aborted immediately, all outputs take reset values, no partial word resumes after release.
- X on din_valid while ready: no requirement. The bench drives known values.

Test Plan:
- Single word, DW=8, MSB_FIRST=1, din=8'h99, one-cycle din_valid at edge k → sout = 1,0,0,1,1,0,0,1 on cycles k..k+7, sout_valid=1 for exactly those 8 cycles, sout_last=1 only on cycle k+7, then sout=0 and sout_valid=0. The downstream detector fires twice (1001 pattern at bits 7..4 and 3..0).
- Back-to-back, din_valid held high with 8'h90 then 8'h09 → 16 contiguous valid bits 1001000000001001. din_ready is high only in IDLE and on cnt==7 cycles, and sout_valid has no gap.
- LSB-first, MSB_FIRST=0, din=8'h01 → sout = 1,0,0,0,0,0,0,0; sout_last on the 8th bit.
- Backpressure: raise din_valid with 8'hFF at cnt==2 of an active word → no accept until cnt==7. The new word's first bit follows the old word's last bit with zero gap, and the old word's bits are undisturbed.
- Reset mid-word: assert rst_n=0 at cnt==4 of 8'hAA → sout=0, sout_valid=0, sout_last=0, din_ready=1 asynchronously. After release with din_valid=0, the line stays idle indefinitely.
- Idle hold: no din_valid for 20 cycles after reset → sout=IDLE_BIT, sout_valid=0, din_ready=1 throughout.
